store_align_buf: RTL and testbench

STORE_ALIGN_BUF -- requirements
Module: store_align_buf

---
 rtl/store_align_buf.sv | 97 +++++++++
 tb/tb_store_align_buf.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/store_align_buf.sv
// Store alignment buffer: registers one EXE-stage store as a byte-lane-aligned data memory request.
// Optional macro STORE_MISALIGN_TRAP_EN rejects misaligned SH/SW and pulses misalign_exc.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module store_align_buf #(
  parameter int unsigned DATA_W = `DATA_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Read_data_sw_EXE,
  input  logic [DATA_W-1:0] alu_result_EXE,
  input  logic [2:0]        funct3_EXE,
  input  logic              MemWrite_EXE,
  input  logic              flush_EXE,
  input  logic              dm_ack,
  output logic              dm_req,
  output logic [DATA_W-1:0] DM_addr,
  output logic [DATA_W-1:0] DM_data_in,
  output logic [3:0]        DM_web,
  output logic              store_busy,
  output logic              misalign_exc
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state;
  logic              legal_f3;
  logic              slot;
  logic              accept;
  logic [3:0]        web_n;
  logic [DATA_W-1:0] data_n;

  // A new store may enter when idle or when the current request completes this cycle.
  always_comb begin
    legal_f3 = (funct3_EXE == 3'b000) || (funct3_EXE == 3'b001) || (funct3_EXE == 3'b010);
    slot     = MemWrite_EXE && !flush_EXE && legal_f3 && ((state == IDLE) || dm_ack);
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = ((funct3_EXE == 3'b001) && alu_result_EXE[0]) ||
                 ((funct3_EXE == 3'b010) && (alu_result_EXE[1:0] != 2'b00));
    accept     = slot && !misaligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_exc <= 1'b0;
    else     misalign_exc <= slot && misaligned;
  end
`else
  always_comb accept = slot;
  assign misalign_exc = 1'b0;
`endif

  always_comb begin
    web_n  = '0;
    data_n = Read_data_sw_EXE;
    case (funct3_EXE)
      3'b000: begin
        web_n  = 4'b0001 << alu_result_EXE[1:0];
        data_n = {(DATA_W/8){Read_data_sw_EXE[7:0]}};
      end
      3'b001: begin
        web_n  = alu_result_EXE[1] ? 4'b1100 : 4'b0011;
        data_n = {(DATA_W/16){Read_data_sw_EXE[15:0]}};
      end
      3'b010:  web_n = 4'b1111;
      default: web_n = '0;
    endcase
  end

  always_comb store_busy = (state == REQ) && !dm_ack && MemWrite_EXE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dm_req     <= 1'b0;
      DM_addr    <= '0;
      DM_data_in <= '0;
      DM_web     <= '0;
    end else if (accept) begin
      state      <= REQ;
      dm_req     <= 1'b1;
      DM_addr    <= {alu_result_EXE[DATA_W-1:2], 2'b00};
      DM_data_in <= data_n;
      DM_web     <= web_n;
    end else if ((state == REQ) && dm_ack) begin
      state  <= IDLE;
      dm_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_store_align_buf.sv
// Randomized scoreboard bench for store_align_buf; expected requests come from a lane-level model.
module tb_store_align_buf;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  web;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Read_data_sw_EXE;
   logic [31:0] alu_result_EXE;
   logic [2:0]  funct3_EXE;
   logic        MemWrite_EXE;
   logic        flush_EXE;
   logic        dm_ack;
   logic        dm_req;
   logic [31:0] DM_addr;
   logic [31:0] DM_data_in;
   logic [3:0]  DM_web;
   logic        store_busy;
   logic        misalign_exc;

   req_t q[$];
   logic pending = 1'b0;
   logic exp_mis = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   store_align_buf #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .Read_data_sw_EXE(Read_data_sw_EXE), .alu_result_EXE(alu_result_EXE),
      .funct3_EXE(funct3_EXE), .MemWrite_EXE(MemWrite_EXE), .flush_EXE(flush_EXE),
      .dm_ack(dm_ack), .dm_req(dm_req), .DM_addr(DM_addr), .DM_data_in(DM_data_in),
      .DM_web(DM_web), .store_busy(store_busy), .misalign_exc(misalign_exc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: memory byte lane n receives the source byte that belongs at address (word + n).
   function automatic req_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      int unsigned size;
      r.addr = a & 32'hFFFF_FFFC;
      r.data = '0;
      r.web  = '0;
      size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int n = 0; n < 4; n++) begin
         r.data[8*n +: 8] = d[8*(n % size) +: 8];
         if (n >= ((size == 4) ? 0 : (size == 2) ? 2 * (a[1] ? 1 : 0) : a[1:0]) &&
             n <  ((size == 4) ? 0 : (size == 2) ? 2 * (a[1] ? 1 : 0) : a[1:0]) + size)
            r.web[n] = 1'b1;
      end
      return r;
   endfunction

   // Called at posedge+#1: drives one cycle of inputs, then records the model's outcome at the next edge.
   task automatic cyc(input logic mw, input logic fl, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d, input logic ack);
      logic legal, mis, slot, acc;
      MemWrite_EXE = mw; flush_EXE = fl; funct3_EXE = f3;
      alu_result_EXE = a; Read_data_sw_EXE = d; dm_ack = ack;
      legal = (f3 <= 3'd2);
      mis   = ((f3 == 3'd1) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'b00));
      slot  = mw && !fl && legal && (!pending || ack);
`ifdef STORE_MISALIGN_TRAP_EN
      acc = slot && !mis;
`else
      acc = slot;
`endif
      @(posedge clk);
      if (acc) q.push_back(model(f3, a, d));
      pending = acc || (pending && !ack);
`ifdef STORE_MISALIGN_TRAP_EN
      exp_mis = slot && mis;
`else
      exp_mis = 1'b0;
`endif
      #1;
   endtask

   // Monitor: the queue front is the outstanding request; it must be presented unchanged until acked.
   always @(negedge clk) begin
      if (!rst) begin
         chk("dm_req", {31'd0, dm_req}, {31'd0, q.size() != 0});
         chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, exp_mis});
         chk("store_busy", {31'd0, store_busy}, {31'd0, (q.size() != 0) && !dm_ack && MemWrite_EXE});
         if (dm_req && q.size() != 0) begin
            chk("DM_addr", DM_addr, q[0].addr);
            chk("DM_data_in", DM_data_in, q[0].data);
            chk("DM_web", {28'd0, DM_web}, {28'd0, q[0].web});
            if (dm_ack) void'(q.pop_front());
         end
      end
   end

   task automatic reset_now();
      rst = 1'b1;
      #1;
      chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
      chk("rst_DM_addr", DM_addr, 32'd0);
      chk("rst_DM_data_in", DM_data_in, 32'd0);
      chk("rst_DM_web", {28'd0, DM_web}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
      q.delete();
      pending = 1'b0;
      exp_mis = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      MemWrite_EXE = 1'b0; flush_EXE = 1'b0; funct3_EXE = 3'd0;
      alu_result_EXE = '0; Read_data_sw_EXE = '0; dm_ack = 1'b0;
      @(posedge clk); #1;
      reset_now();

      // SB to byte lane 3
      cyc(1, 0, 3'd0, 32'h103, 32'h0000_00AB, 0);
      cyc(0, 0, 3'd0, 0, 0, 1);
      // SH upper half, memory stalls while a second store waits
      cyc(1, 0, 3'd1, 32'h202, 32'h0000_1234, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 3'd2, 32'h400, 32'hCAFE_F00D, 0);
      cyc(1, 0, 3'd2, 32'h400, 32'hCAFE_F00D, 1);
      cyc(0, 0, 3'd0, 0, 0, 1);
      // back-to-back SW
      cyc(1, 0, 3'd2, 32'h500, 32'h1111_2222, 0);
      cyc(1, 0, 3'd2, 32'h504, 32'h3333_4444, 1);
      cyc(0, 0, 3'd0, 0, 0, 1);
      // misaligned SW, then rejected stores and ack while idle
      cyc(1, 0, 3'd2, 32'h301, 32'h89AB_CDEF, 0);
      cyc(0, 0, 3'd0, 0, 0, 1);
      cyc(1, 1, 3'd2, 32'h600, 32'h5555_5555, 0);
      cyc(1, 0, 3'd3, 32'h604, 32'h6666_6666, 1);
      cyc(0, 0, 3'd0, 0, 0, 0);
      // reset with a request pending
      cyc(1, 0, 3'd2, 32'h700, 32'h7777_7777, 0);
      reset_now();
      for (int i = 0; i < 3; i++) cyc(0, 0, 3'd0, 0, 0, i[0]);

      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(9) < 6), ($urandom_range(9) < 1),
             (($urandom_range(9) < 1) ? 3'($urandom_range(7)) : 3'($urandom_range(2))),
             $urandom, $urandom, $urandom_range(1) == 1);
      end

      for (int i = 0; i < 4; i++) cyc(0, 0, 3'd0, 0, 0, 1);
      chk("drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
